// File: rtl/alu_result_buffer.sv
// Two-entry in-order skid buffer for ALU results (low/high word, op tag, flags).
// Ports: clk, clr (async active-high); in_* push side; out_* pop side; count, drop_err.
// Optional: define ALU_RESULT_BUFFER_FLAGS_EN to store zero/negative flags per entry.
module alu_result_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_low,
  input  logic [31:0] in_high,
  input  logic [5:0]  in_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_low,
  output logic [31:0] out_high,
  output logic [5:0]  out_sel,
  output logic        flag_z,
  output logic        flag_n,
  output logic [1:0]  count,
  output logic        drop_err
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);
  localparam logic [5:0] SEL_MUL  = 6'd6;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

`ifdef ALU_RESULT_BUFFER_FLAGS_EN
  typedef struct packed {
    logic [31:0] low;
    logic [31:0] high;
    logic [5:0]  sel;
    logic        z;
    logic        n;
  } entry_t;
`else
  typedef struct packed {
    logic [31:0] low;
    logic [31:0] high;
    logic [5:0]  sel;
  } entry_t;
`endif

  state_t state;
  entry_t e0;
  entry_t e1;
  entry_t in_ent;
  logic   push;
  logic   pop;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Flags are frozen at push time; a multiply result spans both words.
  always_comb begin
    in_ent      = '0;
    in_ent.low  = in_low;
    in_ent.high = in_high;
    in_ent.sel  = in_sel;
`ifdef ALU_RESULT_BUFFER_FLAGS_EN
    if (in_sel == SEL_MUL) begin
      in_ent.z = ({in_high, in_low} == 64'd0);
      in_ent.n = in_high[31];
    end else begin
      in_ent.z = (in_low == 32'd0);
      in_ent.n = in_low[31];
    end
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= EMPTY;
      e0       <= '0;
      e1       <= '0;
      drop_err <= 1'b0;
    end else begin
      if (in_valid && !in_ready) drop_err <= 1'b1;
      unique case (state)
        EMPTY: begin
          if (push) begin
            e0    <= in_ent;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            e0 <= in_ent;
          end else if (push) begin
            e1    <= in_ent;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            e0    <= e1;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Head fields read as zero whenever nothing is buffered.
  assign out_low  = out_valid ? e0.low  : 32'd0;
  assign out_high = out_valid ? e0.high : 32'd0;
  assign out_sel  = out_valid ? e0.sel  : 6'd0;

`ifdef ALU_RESULT_BUFFER_FLAGS_EN
  assign flag_z = out_valid && e0.z;
  assign flag_n = out_valid && e0.n;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

  always_comb begin
    count = 2'd0;
    unique case (state)
      EMPTY:   count = 2'd0;
      ONE:     count = 2'd1;
      FULL:    count = FULL_CNT;
      default: count = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: reset, pass-through, overflow,
// backpressure, push+pop, flags (expectations follow ALU_RESULT_BUFFER_FLAGS_EN).
module tb_alu_result_buffer;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_low;
  logic [31:0] in_high;
  logic [5:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_low;
  logic [31:0] out_high;
  logic [5:0]  out_sel;
  logic        flag_z;
  logic        flag_n;
  logic [1:0]  count;
  logic        drop_err;

  int total = 0;
  int bad   = 0;

`ifdef ALU_RESULT_BUFFER_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  alu_result_buffer #(.DEPTH(2)) dut (
    .clk(clk),
    .clr(clr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_low(in_low),
    .in_high(in_high),
    .in_sel(in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_low(out_low),
    .out_high(out_high),
    .out_sel(out_sel),
    .flag_z(flag_z),
    .flag_n(flag_n),
    .count(count),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the DUT samples them on the next rise.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] lo,
                       input logic [31:0] hi, input logic [5:0] s,
                       input logic rdy);
    in_valid  = v;
    in_low    = lo;
    in_high   = hi;
    in_sel    = s;
    out_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'd0, 32'd0, 6'd0, rdy);
  endtask

  initial begin
    clr = 1'b1;
    idle(1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_iready", 32'(in_ready), 32'd1);
    chk("rst_low", out_low, 32'd0);
    chk("rst_drop", 32'(drop_err), 32'd0);
    clr = 1'b0;

    // Empty pop is a no-op.
    idle(1'b1);
    step();
    chk("empty_pop_cnt", 32'(count), 32'd0);

    // Single pass with latency 1, then back to empty.
    drive(1'b1, 32'h5, 32'h0, 6'd0, 1'b1);
    #1;
    chk("nobypass_ov", 32'(out_valid), 32'd0);
    step();
    idle(1'b1);
    chk("pass_ov", 32'(out_valid), 32'd1);
    chk("pass_low", out_low, 32'h5);
    chk("pass_z", 32'(flag_z), 32'd0);
    chk("pass_n", 32'(flag_n), 32'd0);
    chk("pass_cnt", 32'(count), 32'd1);
    step();
    chk("pass_empty_ov", 32'(out_valid), 32'd0);
    chk("pass_empty_low", out_low, 32'd0);

    // Fill, then overflow attempt.
    drive(1'b1, 32'h11, 32'h0, 6'd1, 1'b0);
    step();
    drive(1'b1, 32'h22, 32'h0, 6'd1, 1'b0);
    step();
    drive(1'b1, 32'h33, 32'h0, 6'd1, 1'b0);
    chk("full_cnt", 32'(count), 32'd2);
    chk("full_irdy", 32'(in_ready), 32'd0);
    step();
    idle(1'b0);
    chk("ovf_drop", 32'(drop_err), 32'd1);
    chk("ovf_cnt", 32'(count), 32'd2);

    // Backpressure holds the head steady.
    for (int i = 0; i < 10; i++) begin
      chk("bp_low", out_low, 32'h11);
      chk("bp_irdy", 32'(in_ready), 32'd0);
      step();
    end

    idle(1'b1);
    step();
    chk("pop1_low", out_low, 32'h22);
    chk("pop1_cnt", 32'(count), 32'd1);
    step();
    idle(1'b0);
    chk("pop2_ov", 32'(out_valid), 32'd0);
    chk("pop2_drop", 32'(drop_err), 32'd1);

    // Push and pop together while holding one entry.
    drive(1'b1, 32'hAA, 32'h0, 6'd0, 1'b0);
    step();
    drive(1'b1, 32'hBB, 32'h0, 6'd0, 1'b1);
    chk("pp_head_before", out_low, 32'hAA);
    step();
    idle(1'b1);
    chk("pp_cnt", 32'(count), 32'd1);
    chk("pp_low", out_low, 32'hBB);
    step();
    idle(1'b0);
    chk("pp_drain", 32'(count), 32'd0);

    // Flags: multiply negative, divide zero, plain negative.
    drive(1'b1, 32'h0, 32'h8000_0000, 6'd6, 1'b0);
    step();
    drive(1'b1, 32'h0, 32'h7, 6'd2, 1'b1);
    chk("mul_z", 32'(flag_z), 32'd0);
    chk("mul_n", 32'(flag_n), 32'(FL));
    chk("mul_high", out_high, 32'h8000_0000);
    chk("mul_sel", 32'(out_sel), 32'd6);
    step();
    drive(1'b1, 32'h8000_0000, 32'h0, 6'd0, 1'b1);
    chk("div_z", 32'(flag_z), 32'(FL));
    chk("div_n", 32'(flag_n), 32'd0);
    chk("div_high", out_high, 32'h7);
    chk("div_sel", 32'(out_sel), 32'd2);
    step();
    idle(1'b1);
    chk("neg_z", 32'(flag_z), 32'd0);
    chk("neg_n", 32'(flag_n), 32'(FL));
    step();
    idle(1'b0);
    chk("flags_drain", 32'(count), 32'd0);

    // Async clear mid-FULL.
    drive(1'b1, 32'h44, 32'h0, 6'd0, 1'b0);
    step();
    drive(1'b1, 32'h55, 32'h0, 6'd0, 1'b0);
    step();
    chk("pre_clr_cnt", 32'(count), 32'd2);
    #2;
    clr = 1'b1;
    #1;
    chk("clr_cnt", 32'(count), 32'd0);
    chk("clr_ov", 32'(out_valid), 32'd0);
    chk("clr_irdy", 32'(in_ready), 32'd1);
    chk("clr_drop", 32'(drop_err), 32'd0);
    chk("clr_low", out_low, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    drive(1'b1, 32'h77, 32'h0, 6'd0, 1'b0);
    step();
    idle(1'b0);
    chk("post_clr_low", out_low, 32'h77);
    chk("post_clr_cnt", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered results (fixed at 2; other values unsupported).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port clr  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  producer presents an ALU result this cycle.
REQ-005 SHALL have port in_ready  output  1  buffer accepts a result this cycle.
REQ-006 SHALL have port in_low  input  32  ALU low word (quotient/product low/result).
REQ-007 SHALL have port in_high  input  32  ALU high word (remainder/product high).
REQ-008 SHALL have port in_sel  input  6  ALU operation code tag for the result.
REQ-009 SHALL have port out_valid  output  1  head entry present.
REQ-010 SHALL have port out_ready  input  1  consumer takes head entry this cycle.
REQ-011 SHALL have ports out_low/out_high/out_sel  output  32/32/6  head entry fields.
REQ-012 SHALL have ports flag_z, flag_n  output  1 each  head entry zero/negative flags.
REQ-013 SHALL have port count  output  2  occupancy 0..2.
REQ-014 SHALL have port drop_err  output  1  sticky: push attempted while full.

Function
REQ-015 SHALL implement states EMPTY (count 0), ONE (count 1), FULL (count 2).
REQ-016 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL, decoded from state only (no combinational path from out_ready).
REQ-017 SHALL push when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-018 SHALL drive out_valid = 1 exactly in ONE and FULL.
REQ-019 SHALL make a pushed entry visible on outputs no earlier than the next cycle (latency 1, no bypass).
REQ-020 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE with new entry at head next cycle; FULL+pop->ONE; otherwise hold.
REQ-021 SHALL preserve order: entries leave in acceptance order.
REQ-022 SHALL ignore in_valid while FULL, leave contents unchanged, and set drop_err = 1 until clr.
REQ-023 SHALL hold out_* and flags stable while out_valid && !out_ready.
REQ-024 SHALL drive out_low/out_high/out_sel/flags to 0 in EMPTY.
REQ-025 SHALL compute flags at push and store them with the entry.
REQ-026 For in_sel == 6 (multiply): flag_z = ({in_high,in_low} == 0), flag_n = in_high[31].
REQ-027 For all other in_sel (incl. 2, divide): flag_z = (in_low == 0), flag_n = in_low[31].
REQ-028 SHALL treat out_ready while EMPTY as no-op.

Reset
REQ-029 SHALL, on clr asserted, immediately enter EMPTY with count = 0, out_valid = 0, in_ready = 1, all out_* = 0, flags = 0, drop_err = 0, regardless of clock.
REQ-030 SHALL discard all buffered entries when clr asserts mid-operation; first push after clr deassert behaves as from EMPTY.

Configuration
REQ-031 SHALL honour macro ALU_RESULT_BUFFER_FLAGS_EN: when defined, flag storage and logic per REQ-025..027 compiled in.
REQ-032 SHALL, when ALU_RESULT_BUFFER_FLAGS_EN undefined, omit flag storage and tie flag_z and flag_n to 0; all other behaviour identical.

Verification
REQ-033 Reset: clr=1 mid-FULL -> same cycle count=0, out_valid=0, in_ready=1, drop_err=0.
REQ-034 Single pass: push low=0x00000005 high=0 sel=0, out_ready=1 -> out_valid next cycle with out_low=5, flag_z=0, flag_n=0; EMPTY cycle after.
REQ-035 Fill/overflow: out_ready=0, push 0x11, 0x22, then 0x33 -> count=2, in_ready=0, drop_err=1; pops yield 0x11 then 0x22, 0x33 never appears.
REQ-036 Simultaneous push+pop in ONE: head 0xAA, push 0xBB with out_ready=1 -> count stays 1, out_low=0xBB next cycle.
REQ-037 Flags (FLAGS_EN defined): sel=6 high=0x80000000 low=0 -> flag_z=0, flag_n=1; sel=2 low=0 high=0x7 -> flag_z=1, flag_n=0; macro undefined -> both flags 0.
REQ-038 Backpressure: FULL with out_ready=0 for 10 cycles -> out_* unchanged every cycle, in_ready=0.
